// File: rtl/sm510_ram_arbiter.sv
// SM510 128x4 internal RAM with a single grant point shared by the CPU core,
// the RTC time loader (write bursts) and the LCD segment scanner (display reads).
module sm510_ram_arbiter #(
    parameter int unsigned        ADDR_W    = 7,
    parameter int unsigned        MAX_WAIT  = 15,
    parameter logic [ADDR_W-1:0]  DISP_BASE = 7'h60
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [3:0]        cpu_wdata,
    output logic              cpu_gnt,
    output logic [3:0]        cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ld_req,
    input  logic              ld_last,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [3:0]        ld_wdata,
    output logic              ld_gnt,
    input  logic              sc_req,
    input  logic [4:0]        sc_addr,
    output logic              sc_gnt,
    output logic [3:0]        sc_rdata,
    output logic              sc_rvalid,
    output logic              starve_evt
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] LD_BURST = 1'b1;
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
    localparam int unsigned DEPTH   = 1 << ADDR_W;

    logic [3:0]        mem [0:DEPTH-1];
    logic [0:0]        state_r;
    logic [0:0]        state_nxt_s;
    logic [3:0]        wait_cnt_r;
    logic              forced_s;
    logic              ld_slot_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [3:0]        wr_data_s;
    logic [ADDR_W-1:0] sc_eff_s;
    logic [ADDR_W-1:0] rd_addr_s;

    assign sc_eff_s = DISP_BASE + ADDR_W'(sc_addr);

    // Grant decode: forced scanner slot, then CPU, then loader, then scanner.
    always_comb begin
        forced_s   = 1'b0;
        ld_slot_s  = 1'b0;
        cpu_gnt    = 1'b0;
        ld_gnt     = 1'b0;
        sc_gnt     = 1'b0;
        starve_evt = 1'b0;
        if (rst_n) begin
            forced_s   = sc_req && (wait_cnt_r == WAIT_MAX);
            // During a burst the loader owns the slot even while ld_req is low.
            ld_slot_s  = (state_r == LD_BURST) || ld_req;
            cpu_gnt    = cpu_req && !forced_s;
            ld_gnt     = ld_req && !forced_s && !cpu_req;
            sc_gnt     = sc_req && (forced_s || (!cpu_req && !ld_slot_s));
            starve_evt = forced_s;
        end else begin
            forced_s   = 1'b0;
        end
    end

    // Write/read port steering for the single-port array.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = ld_addr;
        wr_data_s = ld_wdata;
        rd_addr_s = sc_eff_s;
        if (cpu_gnt) begin
            wr_en_s   = cpu_we;
            wr_addr_s = cpu_addr;
            wr_data_s = cpu_wdata;
            rd_addr_s = cpu_addr;
        end else begin
            wr_en_s   = ld_gnt;
        end
    end

    // Loader burst FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (ld_gnt && !ld_last) begin
                    state_nxt_s = LD_BURST;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LD_BURST: begin
                if (ld_gnt && ld_last) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LD_BURST;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // RAM array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_addr_s] <= wr_data_s;
        end
    end

    // FSM state and scanner starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            wait_cnt_r <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            if (!sc_req || sc_gnt) begin
                wait_cnt_r <= 4'd0;
            end else if (wait_cnt_r != WAIT_MAX) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end
        end
    end

    // Registered read data; rvalid pulses one cycle after the read grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata  <= 4'd0;
            cpu_rvalid <= 1'b0;
            sc_rdata   <= 4'd0;
            sc_rvalid  <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_gnt && !cpu_we;
            sc_rvalid  <= sc_gnt;
            if (cpu_gnt && !cpu_we) begin
                cpu_rdata <= mem[rd_addr_s];
            end
            if (sc_gnt) begin
                sc_rdata <= mem[rd_addr_s];
            end
        end
    end

endmodule

// File: tb/tb_sm510_ram_arbiter.sv
// Scoreboard bench for sm510_ram_arbiter: expected read data is queued at the
// grant cycle from a bench-side RAM image and compared when rvalid appears.
module tb_sm510_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [6:0] cpu_addr = 7'd0;
    logic [3:0] cpu_wdata = 4'd0;
    logic       cpu_gnt, cpu_rvalid;
    logic [3:0] cpu_rdata;
    logic       ld_req = 1'b0, ld_last = 1'b0;
    logic [6:0] ld_addr = 7'd0;
    logic [3:0] ld_wdata = 4'd0;
    logic       ld_gnt;
    logic       sc_req = 1'b0;
    logic [4:0] sc_addr = 5'd0;
    logic       sc_gnt, sc_rvalid, starve_evt;
    logic [3:0] sc_rdata;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] model_mem [0:127];
    logic [3:0] cpu_q [$];
    logic [3:0] sc_q [$];

    sm510_ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ld_req(ld_req), .ld_last(ld_last), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt),
        .sc_req(sc_req), .sc_addr(sc_addr), .sc_gnt(sc_gnt), .sc_rdata(sc_rdata),
        .sc_rvalid(sc_rvalid), .starve_evt(starve_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with inputs already driven: check grants, update model, check read data.
    task automatic cyc(input string tag, input logic e_c, input logic e_l,
                       input logic e_s, input logic e_st);
        logic pc, ps;
        logic [3:0] ev;
        logic [6:0] sa;
        #1;
        chk({tag, "/cpu_gnt"}, {7'd0, cpu_gnt}, {7'd0, e_c});
        chk({tag, "/ld_gnt"}, {7'd0, ld_gnt}, {7'd0, e_l});
        chk({tag, "/sc_gnt"}, {7'd0, sc_gnt}, {7'd0, e_s});
        chk({tag, "/starve"}, {7'd0, starve_evt}, {7'd0, e_st});
        sa = 7'h60 + {2'b00, sc_addr};
        pc = e_c && !cpu_we;
        ps = e_s;
        if (pc) cpu_q.push_back(model_mem[cpu_addr]);
        if (ps) sc_q.push_back(model_mem[sa]);
        if (e_c && cpu_we) model_mem[cpu_addr] = cpu_wdata;
        else if (e_l) model_mem[ld_addr] = ld_wdata;
        @(posedge clk);
        #1;
        chk({tag, "/cpu_rvalid"}, {7'd0, cpu_rvalid}, {7'd0, pc});
        chk({tag, "/sc_rvalid"}, {7'd0, sc_rvalid}, {7'd0, ps});
        if (cpu_rvalid && cpu_q.size() > 0) begin
            ev = cpu_q.pop_front();
            chk({tag, "/cpu_rdata"}, {4'd0, cpu_rdata}, {4'd0, ev});
        end
        if (sc_rvalid && sc_q.size() > 0) begin
            ev = sc_q.pop_front();
            chk({tag, "/sc_rdata"}, {4'd0, sc_rdata}, {4'd0, ev});
        end
        cpu_q.delete();
        sc_q.delete();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; ld_req = 1'b0; ld_last = 1'b0; sc_req = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "/cpu_gnt"}, {7'd0, cpu_gnt}, 8'd0);
        chk({tag, "/ld_gnt"}, {7'd0, ld_gnt}, 8'd0);
        chk({tag, "/sc_gnt"}, {7'd0, sc_gnt}, 8'd0);
        chk({tag, "/cpu_rvalid"}, {7'd0, cpu_rvalid}, 8'd0);
        chk({tag, "/sc_rvalid"}, {7'd0, sc_rvalid}, 8'd0);
        chk({tag, "/cpu_rdata"}, {4'd0, cpu_rdata}, 8'd0);
        chk({tag, "/starve"}, {7'd0, starve_evt}, 8'd0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) model_mem[i] = 4'd0;
        #1 rst_n = 1'b0;
        #1 check_reset_outs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single CPU write then read of 0x10
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h10; cpu_wdata = 4'h5;
        cyc("cpu_wr", 1'b1, 1'b0, 1'b0, 1'b0);
        cpu_we = 1'b0;
        cyc("cpu_rd", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("cpu_rd_const", {4'd0, cpu_rdata}, 8'h05);
        idle_inputs();
        cyc("rv_pulse", 1'b0, 1'b0, 1'b0, 1'b0);

        // Preload display locations the scanner will read
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h63; cpu_wdata = 4'hA;
        cyc("pre63", 1'b1, 1'b0, 1'b0, 1'b0);
        cpu_addr = 7'h7F; cpu_wdata = 4'h3;
        cyc("pre7f", 1'b1, 1'b0, 1'b0, 1'b0);
        idle_inputs();
        sc_req = 1'b1; sc_addr = 5'h1F;
        cyc("sc_top", 1'b0, 1'b0, 1'b1, 1'b0);

        // CPU vs scanner contention and starvation guard
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h10;
        sc_req = 1'b1; sc_addr = 5'd3;
        for (int i = 1; i <= 15; i++) cyc("contend", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("forced", 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("cpu_after", 1'b1, 1'b0, 1'b0, 1'b0);
        idle_inputs();
        cyc("gap", 1'b0, 1'b0, 1'b0, 1'b0);

        // Loader burst 0x2A-0x2F with scanner held, CPU preempt and ld_req gap
        sc_req = 1'b1; sc_addr = 5'd3;
        for (int k = 0; k < 6; k++) begin
            ld_req = 1'b1; ld_addr = 7'h2A + 7'(k); ld_wdata = 4'(k + 1);
            ld_last = (k == 5);
            if (k == 3) begin
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h2B;
                cyc("ld_preempt", 1'b1, 1'b0, 1'b0, 1'b0);
                cpu_req = 1'b0;
            end
            cyc("ld_wr", 1'b0, 1'b1, 1'b0, 1'b0);
            if (k == 4) begin
                ld_req = 1'b0;
                cyc("ld_gap", 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        ld_req = 1'b0; ld_last = 1'b0;
        cyc("ld_idle", 1'b0, 1'b0, 1'b1, 1'b0);
        idle_inputs();
        cpu_req = 1'b1; cpu_we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cpu_addr = 7'h2A + 7'(k);
            cyc("ld_rb", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        idle_inputs();

        // Write-first: loader write to 0x61 then scanner read offset 1
        ld_req = 1'b1; ld_last = 1'b1; ld_addr = 7'h61; ld_wdata = 4'h9;
        cyc("wf_wr", 1'b0, 1'b1, 1'b0, 1'b0);
        idle_inputs();
        sc_req = 1'b1; sc_addr = 5'd1;
        cyc("wf_rd", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("wf_const", {4'd0, sc_rdata}, 8'h09);
        idle_inputs();

        // Async reset mid-burst and mid-read
        ld_req = 1'b1; ld_last = 1'b0; ld_addr = 7'h40; ld_wdata = 4'h7;
        cyc("rst_burst", 1'b0, 1'b1, 1'b0, 1'b0);
        ld_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h10;
        #1;
        chk("rst_pre/cpu_gnt", {7'd0, cpu_gnt}, 8'd1);
        @(posedge clk);
        #1;
        chk("rst_pre/cpu_rvalid", {7'd0, cpu_rvalid}, 8'd1);
        ld_req = 1'b1;
        sc_req = 1'b1;
        rst_n = 1'b0;
        #1 check_reset_outs("async_rst");
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        ld_req = 1'b1; ld_last = 1'b1; ld_addr = 7'h41; ld_wdata = 4'hC;
        cyc("post_rst_ld", 1'b0, 1'b1, 1'b0, 1'b0);
        idle_inputs();
        sc_req = 1'b1; sc_addr = 5'd3;
        cyc("post_rst_idle", 1'b0, 1'b0, 1'b1, 1'b0);
        idle_inputs();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h41;
        cyc("post_rst_rd", 1'b1, 1'b0, 1'b0, 1'b0);
        idle_inputs();
        cyc("end", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
